program_loader: RTL and testbench

- Upstream stage of the 8-bit CPU. Fills the 16-byte program RAM from the dedicated input pins before execution starts.
- Accepts one program byte per strobe on an external, asynchronous byte port. Writes bytes to sequential RAM addresses starting at 0.
- Holds the CPU core in reset while loading and releases it when loading ends.
- Its RAM write port is muxed with the input/MAR path in the top level; the loader owns that path whenever cpu_rst_n is low.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/sync_edge_detect.sv | 36 +++
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU slice: program RAM geometry,
// instruction field widths and the program loader's FSM state encoding.
package cpu_pkg;

  // Default program RAM geometry.
  localparam int RAM_BYTES_DEF = 16;
  localparam int ADDR_W_DEF    = 4;

  // Instruction byte layout: {opcode, operand}.
  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 4;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  // Program loader states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } loader_state_t;

  // Opcode field of an instruction byte.
  function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:OPERAND_W];
  endfunction

  // Operand field of an instruction byte.
  function automatic logic [OPERAND_W-1:0] instr_operand(input logic [INSTR_W-1:0] instr);
    return instr[OPERAND_W-1:0];
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a delay
// flop and a registered one-cycle rising-edge pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Synchronise the input, keep a one-cycle delayed copy, register the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= w_level;
      r_rise <= w_level & ~r_dly;
    end
  end

  assign o_level = w_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/program_loader.sv
// Program loader: fills program RAM from an asynchronous byte port while
// holding the CPU core in reset, then releases the core when load mode ends.
//
// Handshake: the byte port has no ready. A rising edge on byte_strobe marks
// byte_in valid; byte_in must be stable from SYNC_STAGES+1 cycles before the
// strobe rises until it falls. The RAM side is a fire-and-forget write:
// ram_we is a one-cycle pulse with ram_addr/ram_data stable for that cycle,
// and the RAM is assumed to always accept it.
module program_loader
  import cpu_pkg::*;
#(
  parameter int RAM_BYTES   = RAM_BYTES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              byte_strobe,
  input  logic [7:0]        byte_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   byte_count,
  output logic              full,
  output logic              overflow,
  output loader_state_t     o_dbg_state
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(RAM_BYTES);
  localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_data;
  logic              r_ram_we;
  logic              r_cpu_rst_n;
  logic [ADDR_W:0]   r_byte_count;
  logic              r_full;
  logic              r_overflow;

  logic              w_mode;
  logic              w_mode_rise;
  logic              w_strobe_level;
  logic              w_strobe_rise;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (load_mode),
    .o_level (w_mode),
    .o_rise  (w_mode_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (byte_strobe),
    .o_level (w_strobe_level),
    .o_rise  (w_strobe_rise)
  );

  // Only the load_mode level and the strobe edge drive the FSM.
  assign w_unused    = w_mode_rise ^ w_strobe_level;
  assign w_count_inc = r_byte_count + ONE;

  // Loader FSM; all outputs are registered alongside the state, and
  // cpu_rst_n is set from the state being entered on each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ram_we     <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
      r_byte_count <= '0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_mode) begin
            // New session: restart at address 0 with clean flags.
            r_state      <= ST_LOAD;
            r_byte_count <= '0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
          end else begin
            r_cpu_rst_n <= 1'b1;
          end
        end
        ST_LOAD: begin
          // load_mode falling takes priority over a coincident strobe.
          if (!w_mode) begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
          end else if (w_strobe_rise) begin
            r_state     <= ST_WRITE;
            r_ram_data  <= byte_in;
            r_ram_addr  <= r_byte_count[ADDR_W-1:0];
            r_ram_we    <= 1'b1;
            r_cpu_rst_n <= 1'b0;
          end else begin
            r_cpu_rst_n <= 1'b0;
          end
        end
        ST_WRITE: begin
          // The write always completes; address/data stay put afterwards.
          r_byte_count <= w_count_inc;
          if (w_count_inc == FULL_COUNT) begin
            r_full      <= 1'b1;
            r_state     <= ST_FULL;
            r_cpu_rst_n <= 1'b0;
          end else if (w_mode) begin
            r_state     <= ST_LOAD;
            r_cpu_rst_n <= 1'b0;
          end else begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
          end
        end
        ST_FULL: begin
          if (w_strobe_rise) begin
            r_overflow <= 1'b1;
          end
          if (!w_mode) begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
          end else begin
            r_cpu_rst_n <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_cpu_rst_n <= 1'b1;
        end
      endcase
    end
  end

  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign ram_we      = r_ram_we;
  assign cpu_rst_n   = r_cpu_rst_n;
  assign byte_count  = r_byte_count;
  assign full        = r_full;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed sequence with random
// data, a write scoreboard with expected cycle/address/data, and a simple
// session model (count, full, overflow, mode).
module tb_program_loader;
  import cpu_pkg::*;

  localparam int SYNC   = 2;
  localparam int NBYTES = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_mode = 1'b0;
  logic          byte_strobe = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic [3:0]    ram_addr;
  logic [7:0]    ram_data;
  logic          ram_we;
  logic          cpu_rst_n;
  logic [4:0]    byte_count;
  logic          full;
  logic          overflow;
  loader_state_t dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader #(.RAM_BYTES(NBYTES), .ADDR_W(4), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_mode   (load_mode),
    .byte_strobe (byte_strobe),
    .byte_in     (byte_in),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .ram_we      (ram_we),
    .cpu_rst_n   (cpu_rst_n),
    .byte_count  (byte_count),
    .full        (full),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Expected write: {cycle of ram_we sample, address, data}
  logic [43:0] exp_q[$];

  // Session model
  int m_count = 0;
  bit m_full  = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_load  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every ram_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        check("we_cycle", cyc, e[43:12]);
        check("we_addr", {28'd0, ram_addr}, {28'd0, e[11:8]});
        check("we_data", {24'd0, ram_data}, {24'd0, e[7:0]});
        check("cpu_rst_n_in_write", {31'd0, cpu_rst_n}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_expect_byte(input logic [7:0] b);
    if (m_load) begin
      if (m_count < NBYTES) begin
        exp_q.push_back({32'(cyc + SYNC + 2), 4'(m_count), b});
        m_count++;
        if (m_count == NBYTES) m_full = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    repeat (SYNC + 1) @(negedge clk);
    byte_strobe = 1'b1;
    model_expect_byte(b);
    repeat (SYNC + 3) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (SYNC + 3 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic enter_load();
    @(negedge clk);
    load_mode = 1'b1;
    m_load  = 1'b1;
    m_count = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic leave_load();
    @(negedge clk);
    load_mode = 1'b0;
    m_load = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, {27'd0, byte_count}, 32'(m_count));
    check({tag, "_full"}, {31'd0, full}, {31'd0, m_full});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, ~m_load});
  endtask

  // Hard stop if something wedges the sequence.
  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b;
    bit seen;

    // Reset with load_mode low.
    repeat (3) @(negedge clk);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_count", {27'd0, byte_count}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_RUN));
    check("rst_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_data", {24'd0, ram_data}, 32'd0);
    check("rst_flags", {30'd0, full, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Three bytes.
    enter_load();
    check("load_state", 32'(dbg_state), 32'(ST_LOAD));
    check("load_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send_byte(8'h1E);
    send_byte(8'h2F);
    send_byte(8'hE0);
    check_status("three");

    // Fill all 16 locations, then one extra byte.
    leave_load();
    enter_load();
    for (int i = 0; i < NBYTES - 1; i++) send_byte(8'(i));
    check("not_full_at_15", {31'd0, full}, 32'd0);
    send_byte(8'h0F);
    check_status("sixteen");
    check("full_state", 32'(dbg_state), 32'(ST_FULL));
    send_byte(8'hAA);
    check_status("overflow");
    check("no_wrap_addr", {28'd0, ram_addr}, 32'd15);
    leave_load();
    check("after_full_state", 32'(dbg_state), 32'(ST_RUN));
    check_status("after_full");

    // Drop load_mode after five random bytes.
    enter_load();
    check("reentry_ovf_clear", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    load_mode = 1'b0;
    m_load = 1'b0;
    @(negedge clk);
    check("drop_cpu_rst_n_e1", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    check("drop_cpu_rst_n_e2", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    check("drop_cpu_rst_n_e3", {31'd0, cpu_rst_n}, 32'd1);
    check("drop_state", 32'(dbg_state), 32'(ST_RUN));
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    check_status("run_ignores");

    // Strobe edge and load_mode fall reach the FSM together.
    enter_load();
    send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    byte_in = 8'($urandom_range(0, 255));
    repeat (SYNC + 1) @(negedge clk);
    byte_strobe = 1'b1;
    @(negedge clk);
    load_mode = 1'b0;
    m_load = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    check("simul_state", 32'(dbg_state), 32'(ST_RUN));
    check_status("simul");

    // Reset asserted while the write pulse is high.
    enter_load();
    @(negedge clk);
    byte_in = 8'($urandom_range(0, 255));
    repeat (SYNC + 1) @(negedge clk);
    byte_strobe = 1'b1;
    model_expect_byte(byte_in);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (ram_we === 1'b1) seen = 1'b1;
    end
    check("midreset_we_seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    m_count = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    #1;
    check("midreset_we_drop", {31'd0, ram_we}, 32'd0);
    check("midreset_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("midreset_state", 32'(dbg_state), 32'(ST_RUN));
    check("midreset_count", {27'd0, byte_count}, 32'd0);
    load_mode = 1'b0;
    m_load = 1'b0;
    byte_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postreset_state", 32'(dbg_state), 32'(ST_RUN));
    check_status("postreset");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
